// File: rtl/crc_tx_append.sv
// Transmit-side CRC-16 appender: forwards payload bytes unchanged, then emits
// the frame CRC (high byte, then low byte) through a single output register.
module crc_tx_append #(
  parameter logic [15:0] POLY = 16'h1021,
  parameter logic [15:0] INIT = 16'hFFFF
) (
  input  logic        clk50m,
  input  logic        rst,
  input  logic        crc_start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] crc_value,
  output logic        crc_done
);

  typedef enum logic [1:0] {S_DATA, S_CRC_HI, S_CRC_LO, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        fresh_q, fresh_d;
  logic [15:0] crc_q, crc_d;
  logic        slot_free;
  logic [15:0] crc_base;

  function automatic logic [15:0] crc_next(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] x;
    x = c ^ {d, 8'h00};
    for (int i = 0; i < 8; i++) begin
      x = x[15] ? ((x << 1) ^ POLY) : (x << 1);
    end
    return x;
  endfunction

  assign slot_free = !valid_q || out_ready;
  // crc_value keeps showing the finished frame's CRC; the next frame starts from INIT.
  assign crc_base  = fresh_q ? INIT : crc_q;

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    valid_d  = valid_q;
    last_d   = last_q;
    crc_d    = crc_q;
    fresh_d  = fresh_q;
    done_d   = 1'b0;
    in_ready = 1'b0;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (crc_start) begin
      crc_d   = INIT;
      fresh_d = 1'b0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      state_d = S_DATA;
    end else begin
      case (state_q)
        S_DATA: begin
          in_ready = slot_free;
          if (in_valid && slot_free) begin
            data_d  = in_data;
            valid_d = 1'b1;
            last_d  = 1'b0;
            crc_d   = crc_next(crc_base, in_data);
            fresh_d = 1'b0;
            if (in_last) begin
              state_d = S_CRC_HI;
            end
          end
        end
        S_CRC_HI: begin
          if (slot_free) begin
            data_d  = crc_q[15:8];
            valid_d = 1'b1;
            last_d  = 1'b0;
            state_d = S_CRC_LO;
          end
        end
        S_CRC_LO: begin
          if (slot_free) begin
            data_d  = crc_q[7:0];
            valid_d = 1'b1;
            last_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (valid_q && out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            fresh_d = 1'b1;
            state_d = S_DATA;
          end
        end
        default: state_d = S_DATA;
      endcase
    end
  end

  always_ff @(posedge clk50m) begin
    if (rst) begin
      state_q <= S_DATA;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      fresh_q <= 1'b0;
      crc_q   <= INIT;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      fresh_q <= fresh_d;
      crc_q   <= crc_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign crc_value = crc_q;
  assign crc_done  = done_q;

endmodule

// File: tb/tb_crc_tx_append.sv
// Randomized bench for crc_tx_append against a bit-serial CRC reference model
// and an expected-output byte queue.
module tb_crc_tx_append;

  localparam logic [15:0] POLY = 16'h1021;
  localparam logic [15:0] INIT = 16'hFFFF;

  logic        clk50m;
  logic        rst;
  logic        crc_start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;
  logic [15:0] crc_value;
  logic        crc_done;

  crc_tx_append #(.POLY(POLY), .INIT(INIT)) dut (
    .clk50m    (clk50m),
    .rst       (rst),
    .crc_start (crc_start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .crc_value (crc_value),
    .crc_done  (crc_done)
  );

  initial clk50m = 1'b0;
  always #10 clk50m = ~clk50m;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;

  logic [7:0]  frame_q[$];
  logic [7:0]  exp_q[$];
  bit          exp_last_q[$];
  logic [15:0] m_crc;
  logic [15:0] exp_frame_crc;
  bit          crc_phase;
  bit          exp_done;
  bit          prev_stall;
  logic [7:0]  prev_data;
  bit          acc;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Bit-serial polynomial division, one message bit at a time.
  function automatic logic [15:0] ref_crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic fb;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ b[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ POLY;
    end
    return c;
  endfunction

  task automatic tick();
    bit hs;
    bit hs_low;
    logic [7:0] e;
    bit el;
    @(negedge clk50m);
    hs = out_valid && out_ready;
    hs_low = 1'b0;
    check("in_ready", in_ready, !crc_start && !crc_phase && (!out_valid || out_ready));
    check("crc_done", crc_done, exp_done);
    if (crc_done) begin
      done_cnt++;
      check("crc_value_at_done", crc_value, exp_frame_crc);
    end
    if (prev_stall) begin
      check("hold_valid", out_valid, 1'b1);
      check("hold_data", out_data, prev_data);
    end
    if (hs) begin
      check("byte_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e  = exp_q.pop_front();
        el = exp_last_q.pop_front();
        check("out_data", out_data, e);
        check("out_last", out_last, el);
        hs_low = el;
      end
    end
    acc = in_valid && in_ready;
    if (rst || crc_start) begin
      exp_q.delete();
      exp_last_q.delete();
      m_crc      = INIT;
      crc_phase  = 1'b0;
      exp_done   = 1'b0;
      prev_stall = 1'b0;
      acc        = 1'b0;
    end else begin
      exp_done = hs_low;
      if (hs_low) crc_phase = 1'b0;
      if (acc) begin
        m_crc = ref_crc_byte(m_crc, in_data);
        exp_q.push_back(in_data);
        exp_last_q.push_back(1'b0);
        if (in_last) begin
          exp_frame_crc = m_crc;
          exp_q.push_back(m_crc[15:8]);
          exp_last_q.push_back(1'b0);
          exp_q.push_back(m_crc[7:0]);
          exp_last_q.push_back(1'b1);
          m_crc     = INIT;
          crc_phase = 1'b1;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
    @(posedge clk50m);
    #1;
  endtask

  task automatic send_frame(input bit rnd, input bit with_last);
    int idx;
    int guard;
    idx = 0;
    guard = 0;
    while (idx < frame_q.size() && guard < 500) begin
      in_valid  = 1'b1;
      in_data   = frame_q[idx];
      in_last   = with_last && (idx == frame_q.size() - 1);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (idx != frame_q.size()) check("send_timeout", idx, frame_q.size());
  endtask

  task automatic drain(input bit rnd);
    int g;
    g = 0;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || crc_phase || exp_done) && g < 300) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      g++;
    end
    if (g >= 300) check("drain_timeout", g, 0);
    out_ready = 1'b1;
    tick();
  endtask

  task automatic load_t1();
    frame_q.delete();
    for (int i = 0; i < 9; i++) frame_q.push_back(8'h31 + 8'(i));
  endtask

  initial begin
    int d0;
    int len;
    rst = 1'b1; crc_start = 1'b0; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b0;
    m_crc = INIT; exp_frame_crc = INIT; crc_phase = 0; exp_done = 0; prev_stall = 0;
    prev_data = 8'h00; acc = 0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 8'h00);
    check("rst_out_last", out_last, 1'b0);
    check("rst_crc_done", crc_done, 1'b0);
    check("rst_crc_value", crc_value, 16'hFFFF);
    check("rst_in_ready", in_ready, 1'b1);

    // T1
    d0 = done_cnt;
    load_t1();
    send_frame(1'b0, 1'b1);
    drain(1'b0);
    check("t1_crc", crc_value, 16'h29B1);
    check("t1_done_cnt", done_cnt - d0, 1);

    // T2
    d0 = done_cnt;
    frame_q.delete();
    frame_q.push_back(8'h41);
    send_frame(1'b0, 1'b1);
    drain(1'b0);
    check("t2_crc", crc_value, 16'hB915);
    check("t2_done_cnt", done_cnt - d0, 1);

    // T3
    load_t1();
    send_frame(1'b1, 1'b1);
    drain(1'b1);
    check("t3_crc", crc_value, 16'h29B1);

    // T4
    d0 = done_cnt;
    frame_q.delete();
    frame_q.push_back(8'h41);
    send_frame(1'b0, 1'b1);
    load_t1();
    send_frame(1'b0, 1'b1);
    drain(1'b0);
    check("t4_crc", crc_value, 16'h29B1);
    check("t4_done_cnt", done_cnt - d0, 2);

    // T5
    frame_q.delete();
    for (int i = 0; i < 4; i++) frame_q.push_back(8'h31 + 8'(i));
    send_frame(1'b0, 1'b0);
    out_ready = 1'b0;
    crc_start = 1'b1;
    tick();
    crc_start = 1'b0;
    check("t5_valid_drop", out_valid, 1'b0);
    check("t5_crc_init", crc_value, 16'hFFFF);
    load_t1();
    send_frame(1'b0, 1'b1);
    drain(1'b0);
    check("t5_crc", crc_value, 16'h29B1);

    // T6
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h31; in_last = 1'b0;
    tick();
    in_data = 8'h32;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_out_valid", out_valid, 1'b0);
    check("t6_crc_value", crc_value, 16'hFFFF);
    check("t6_in_ready", in_ready, 1'b1);

    // Random frames
    for (int f = 0; f < 8; f++) begin
      d0 = done_cnt;
      len = $urandom_range(1, 12);
      frame_q.delete();
      for (int i = 0; i < len; i++) frame_q.push_back(8'($urandom));
      send_frame(1'b1, 1'b1);
      drain(1'b1);
      check("rnd_crc", crc_value, exp_frame_crc);
      check("rnd_done_cnt", done_cnt - d0, 1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
